// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and helpers for the CAP19 fetch stage.
//   WORD_LEN        : datapath / address width
//   FETCH_RESET_PC  : first program word loaded on reset
//   FETCH_PC_STEP   : memory cells per instruction (4 x 4-bit cells)
//   HALT_WORD       : instruction word that stops fetch when halt is built in
//   NOP_WORD        : word placed in IF/ID for a bubble
package fetch_stage_pkg;

  localparam int WORD_LEN = 16;

  localparam logic [WORD_LEN-1:0] FETCH_RESET_PC = 16'd8;
  localparam logic [WORD_LEN-1:0] FETCH_PC_STEP  = 16'd4;
  localparam logic [WORD_LEN-1:0] HALT_WORD      = 16'hFFFF;
  localparam logic [WORD_LEN-1:0] NOP_WORD       = 16'h0000;

  // Branch targets are forced onto a cell-group boundary.
  function automatic logic [WORD_LEN-1:0] align_target(input logic [WORD_LEN-1:0] addr);
    return {addr[WORD_LEN-1:2], 2'b00};
  endfunction

  function automatic logic is_halt_word(input logic [WORD_LEN-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst     : clock, synchronous active-low reset
//   hold         : keep current contents (stall)
//   clear        : load a bubble (flush); wins over hold
//   instr_in, pc_in, pc_next_in : values captured on a normal load
//   instr, pc, pc_next, valid   : registered outputs to decode
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                clear,
  input  logic [WORD_LEN-1:0] instr_in,
  input  logic [WORD_LEN-1:0] pc_in,
  input  logic [WORD_LEN-1:0] pc_next_in,
  output logic [WORD_LEN-1:0] instr,
  output logic [WORD_LEN-1:0] pc,
  output logic [WORD_LEN-1:0] pc_next,
  output logic                valid
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      instr   <= NOP_WORD;
      pc      <= '0;
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (!hold) begin
      instr   <= instr_in;
      pc      <= pc_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: CAP19 instruction fetch. Owns the PC, addresses the
// combinational instruction memory and registers the returned word into IF/ID.
//   clk, rst        : clock, synchronous active-low reset
//   stall           : freeze PC and IF/ID
//   branch_taken    : redirect from execute (overrides stall), flushes IF/ID
//   branch_target   : redirect address, low two bits ignored
//   instruction     : memory word for pc_out
//   pc_out          : current PC / memory address
//   if_id_instr, if_id_pc, if_id_pc_next, if_id_valid : IF/ID register
//   halted          : fetch stopped on HALT_WORD
// Build option: define FETCH_HALT_EN to add the RUN/HALTED FSM; without it
// the halt word is fetched like any other and halted is tied low.
//
// state      | meaning
// ST_RUN     | fetching normally
// ST_HALTED  | halt word captured; PC frozen, IF/ID emits bubbles until a branch
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [WORD_LEN-1:0] PC_STEP  = FETCH_PC_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  input  logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic [WORD_LEN-1:0] if_id_instr,
  output logic [WORD_LEN-1:0] if_id_pc,
  output logic [WORD_LEN-1:0] if_id_pc_next,
  output logic                if_id_valid,
  output logic                halted
);

  logic [WORD_LEN-1:0] pc_q;
  logic [WORD_LEN-1:0] pc_plus;
  logic                halt_state;

  assign pc_plus = pc_q + PC_STEP;  // wraps modulo 2^WORD_LEN
  assign pc_out  = pc_q;

`ifdef FETCH_HALT_EN
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else if (branch_taken) begin
      state <= ST_RUN;
    end else if (state == ST_RUN && !stall && is_halt_word(instruction)) begin
      state <= ST_HALTED;
    end
  end

  assign halt_state = (state == ST_HALTED);
  assign halted     = halt_state;
`else
  assign halt_state = 1'b0;
  assign halted     = 1'b0;
`endif

  // The capturing edge of the halt word still advances the PC; it is the
  // following edges that freeze it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (branch_taken) begin
      pc_q <= align_target(branch_target);
    end else if (!halt_state && !stall) begin
      pc_q <= pc_plus;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (stall),
    .clear      (branch_taken || halt_state),
    .instr_in   (instruction),
    .pc_in      (pc_q),
    .pc_next_in (pc_plus),
    .instr      (if_id_instr),
    .pc         (if_id_pc),
    .pc_next    (if_id_pc_next),
    .valid      (if_id_valid)
  );

endmodule
